// File: rtl/pico_io_responder.sv
// PicoBlaze I/O port responder: output/control registers, receive FIFO and level interrupt.
// Optional 8-bit prescaled timer at BASE_ADDR+4 when PICO_IO_TIMER_EN is defined.
module pico_io_responder #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         FIFO_DEPTH = 8,
  parameter int         TIMER_DIV  = 100
) (
  input  logic       clk,
  input  logic       cpu_reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       k_write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] ext_data,
  input  logic       ext_valid,
  output logic       ext_ready,
  output logic [7:0] led_out
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [7:0] A_LED  = BASE_ADDR;
  localparam logic [7:0] A_STAT = BASE_ADDR + 8'd1;
  localparam logic [7:0] A_FIFO = BASE_ADDR + 8'd2;
  localparam logic [7:0] A_IRQ  = BASE_ADDR + 8'd3;
  localparam logic [7:0] A_TMR  = BASE_ADDR + 8'd4;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pico_io_responder: FIFO_DEPTH must be a power of 2 in 2..256");
  end
  if (TIMER_DIV < 1) begin : g_bad_div
    $error("pico_io_responder: TIMER_DIV must be 1 or more");
  end

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_PEND     = 2'd1,
    IRQ_SERVICED = 2'd2
  } irq_state_t;

  logic             wr_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [7:0]       head_s;
  logic [7:0]       rd_data_s;
  logic [7:0]       timer_s;
  logic [7:0]       led_r;
  logic             irq_en_r;
  logic             overflow_r;
  logic [7:0]       in_port_r;
  logic             interrupt_r;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  irq_state_t       state_r;
  irq_state_t       state_s;

  assign wr_s    = write_strobe | k_write_strobe;
  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  assign push_s  = ext_valid & ~full_s;
  assign pop_s   = read_strobe & (port_id == A_FIFO) & ~empty_s;
  assign head_s  = empty_s ? 8'h00 : mem_r[rd_ptr_r];

  // Processor-writable registers and the sticky overflow flag
  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      led_r      <= 8'h00;
      irq_en_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s && (port_id == A_LED)) led_r <= out_port;
      if (wr_s && (port_id == A_IRQ)) irq_en_r <= out_port[0];
      // A new overflow wins over a simultaneous clear
      if (ext_valid && full_s) overflow_r <= 1'b1;
      else if (wr_s && (port_id == A_STAT) && out_port[2]) overflow_r <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= ext_data;
  end

`ifdef PICO_IO_TIMER_EN
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  logic [PW-1:0] presc_r;
  logic [7:0]    timer_r;

  // Prescaled free-running timer; any write to its port clears both stages
  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      presc_r <= {PW{1'b0}};
      timer_r <= 8'h00;
    end else if (wr_s && (port_id == A_TMR)) begin
      presc_r <= {PW{1'b0}};
      timer_r <= 8'h00;
    end else if (presc_r == PW'(TIMER_DIV - 1)) begin
      presc_r <= {PW{1'b0}};
      timer_r <= timer_r + 8'd1;
    end else begin
      presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end
  assign timer_s = timer_r;
`else
  assign timer_s = 8'h00;
`endif

  // Read mux, registered every clock regardless of read_strobe
  always_comb begin
    rd_data_s = 8'h00;
    case (port_id)
      A_LED:   rd_data_s = led_r;
      A_STAT:  rd_data_s = {5'b00000, overflow_r, full_s, ~empty_s};
      A_FIFO:  rd_data_s = head_s;
      A_IRQ:   rd_data_s = {7'b0000000, irq_en_r};
      A_TMR:   rd_data_s = timer_s;
      default: rd_data_s = 8'h00;
    endcase
  end

  // IRQ state next-state logic; SERVICED holds off re-arming until the FIFO drains
  always_comb begin
    state_s = state_r;
    case (state_r)
      IRQ_IDLE: begin
        if (irq_en_r && !empty_s) state_s = IRQ_PEND;
        else state_s = IRQ_IDLE;
      end
      IRQ_PEND: begin
        if (interrupt_ack) state_s = IRQ_SERVICED;
        else if (!irq_en_r) state_s = IRQ_IDLE;
        else state_s = IRQ_PEND;
      end
      IRQ_SERVICED: begin
        if (empty_s) state_s = IRQ_IDLE;
        else state_s = IRQ_SERVICED;
      end
      default: state_s = IRQ_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_r     <= IRQ_IDLE;
      interrupt_r <= 1'b0;
      in_port_r   <= 8'h00;
    end else begin
      state_r     <= state_s;
      interrupt_r <= (state_s == IRQ_PEND);
      in_port_r   <= rd_data_s;
    end
  end

  assign in_port   = in_port_r;
  assign interrupt = interrupt_r;
  assign led_out   = led_r;
  assign ext_ready = ~full_s;

endmodule

// File: tb/tb_pico_io_responder.sv
// Directed self-checking bench for pico_io_responder with a FIFO data scoreboard.
module tb_pico_io_responder;

  localparam int         DEPTH = 8;
  localparam logic [7:0] BASE  = 8'h00;

  logic       clk;
  logic       cpu_reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic [7:0] led_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] fifo_m [$];
  logic       ovf_m = 1'b0;
  logic [7:0] d;

  pico_io_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TIMER_DIV(4)) dut (
    .clk(clk), .cpu_reset(cpu_reset), .port_id(port_id),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .ext_data(ext_data), .ext_valid(ext_valid), .ext_ready(ext_ready),
    .led_out(led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v, input bit k);
    port_id = a;
    out_port = v;
    if (k) k_write_strobe = 1'b1;
    else write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    k_write_strobe = 1'b0;
  endtask

  // Two-cycle INPUT: data sampled while read_strobe is high
  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    port_id = a;
    tick();
    v = in_port;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    ext_data = b;
    ext_valid = 1'b1;
    if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
    else ovf_m = 1'b1;
    tick();
    ext_valid = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    e = {5'b00000, ovf_m, (fifo_m.size() == DEPTH), (fifo_m.size() != 0)};
    rd(BASE + 8'd1, v);
    chk(tag, v, e);
  endtask

  task automatic chk_head(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    rd(BASE + 8'd2, v);
    if (fifo_m.size() > 0) e = fifo_m.pop_front();
    else e = 8'h00;
    chk(tag, v, e);
  endtask

  initial begin
    cpu_reset = 1'b1;
    port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; ext_data = 8'h00; ext_valid = 1'b0;
    repeat (3) tick();
    chk("rst_led", led_out, 8'h00);
    chk("rst_in_port", in_port, 8'h00);
    chk("rst_ready", {7'b0000000, ext_ready}, 8'h01);
    chk("rst_irq", {7'b0000000, interrupt}, 8'h00);
    cpu_reset = 1'b0;
    tick();

    wr(BASE, 8'hF3, 1'b0);
    chk("wr_led", led_out, 8'hF3);
    rd(BASE, d);
    chk("rd_led", d, 8'hF3);

    wr(BASE, 8'h60, 1'b1);
    chk("wrk_led", led_out, 8'h60);
    wr(BASE + 8'd7, 8'h55, 1'b0);
    chk("unmapped_led", led_out, 8'h60);
    rd(BASE + 8'd7, d);
    chk("unmapped_rd", d, 8'h00);
    rd(BASE + 8'd3, d);
    chk("irq_en_rst", d, 8'h00);
    chk_status("stat_idle");

    push(8'hA1); push(8'hB2); push(8'hC3);
    chk_status("stat_3");
    chk_head("pop_a1"); chk_head("pop_b2"); chk_head("pop_c3");
    chk_status("stat_empty");
    chk_head("pop_empty");

    for (int i = 0; i < DEPTH; i++) push(8'(8'd16 + 8'(i * 7)));
    chk("ready_full", {7'b0000000, ext_ready}, 8'h00);
    chk_status("stat_full");
    push(8'hEE);
    chk_status("stat_ovf");
    wr(BASE + 8'd1, 8'h04, 1'b0);
    ovf_m = 1'b0;
    chk_status("stat_ovf_clr");
    for (int i = 0; i < DEPTH; i++) chk_head("drain");
    chk_status("stat_drained");

    push(8'h11);
    port_id = BASE + 8'd2;
    tick();
    chk("pp_head", in_port, fifo_m.pop_front());
    read_strobe = 1'b1; ext_valid = 1'b1; ext_data = 8'h22;
    fifo_m.push_back(8'h22);
    tick();
    read_strobe = 1'b0; ext_valid = 1'b0;
    chk_status("pp_count1");
    chk_head("pp_new_head");

    wr(BASE + 8'd3, 8'h01, 1'b0);
    rd(BASE + 8'd3, d);
    chk("irq_en_set", d, 8'h01);
    chk("irq_idle_empty", {7'b0000000, interrupt}, 8'h00);
    push(8'h33);
    tick();
    chk("irq_pend", {7'b0000000, interrupt}, 8'h01);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("irq_acked", {7'b0000000, interrupt}, 8'h00);
    push(8'h44);
    tick(); tick();
    chk("irq_no_storm", {7'b0000000, interrupt}, 8'h00);
    chk_head("isr_pop1"); chk_head("isr_pop2");
    push(8'h55);
    tick();
    chk("irq_rearm", {7'b0000000, interrupt}, 8'h01);
    wr(BASE + 8'd3, 8'h00, 1'b0);
    tick();
    chk("irq_en_clr", {7'b0000000, interrupt}, 8'h00);

    wr(BASE + 8'd3, 8'h01, 1'b0);
    tick(); tick();
    chk("irq_pre_rst", {7'b0000000, interrupt}, 8'h01);
    #2 cpu_reset = 1'b1;
    #1;
    chk("mid_rst_irq", {7'b0000000, interrupt}, 8'h00);
    chk("mid_rst_led", led_out, 8'h00);
    fifo_m.delete();
    ovf_m = 1'b0;
    tick();
    cpu_reset = 1'b0;
    chk_status("mid_rst_stat");
    chk_head("mid_rst_head");

`ifdef PICO_IO_TIMER_EN
    wr(BASE + 8'd4, 8'h00, 1'b0);
    repeat (42) tick();
    chk("timer_count", in_port, 8'h0A);
    wr(BASE + 8'd4, 8'h9C, 1'b0);
    tick();
    chk("timer_clr", in_port, 8'h00);
`else
    repeat (40) tick();
    rd(BASE + 8'd4, d);
    chk("timer_absent", d, 8'h00);
    wr(BASE + 8'd4, 8'h5A, 1'b0);
    rd(BASE + 8'd4, d);
    chk("timer_absent_wr", d, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pico_io_responder.md
Name: pico_io_responder

Overview:
- Peripheral-side responder for the PicoBlaze I/O port bus.
- Decodes port_id, latches the processor's write data (write_strobe / k_write_strobe) into an output register and a control register.
- Supplies in_port data back to the processor: a registered read mux plus a receive FIFO that buffers external bytes for the processor to pop.
- Raises a level interrupt cleared by interrupt_ack. Sits beside pico_top and drives its in_port, interrupt and output pins.

Parameters:
- BASE_ADDR, 8'h00, port_id of register 0; the block occupies BASE_ADDR..BASE_ADDR+4.
- FIFO_DEPTH, 8, receive FIFO entries; power of 2, from 2 to 256.
- TIMER_DIV, 100, clocks per timer increment (optional feature only); 1 or more.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- cpu_reset  in  1  asynchronous, active-high reset.
- port_id  in  8  processor port address.
- write_strobe  in  1  one-cycle OUTPUT strobe.
- k_write_strobe  in  1  one-cycle OUTPUTK strobe.
- read_strobe  in  1  one-cycle INPUT strobe.
- out_port  in  8  processor write data.
- in_port  out  8  registered read data to processor.
- interrupt  out  1  interrupt request, level.
- interrupt_ack  in  1  one-cycle acknowledge from processor.
- ext_data  in  8  external byte to buffer.
- ext_valid  in  1  ext_data valid.
- ext_ready  out  1  FIFO can accept; equals !full (combinational).
- led_out  out  8  output register contents.

Behaviour:
- Reset (async, cpu_reset=1) values:
  - in_port=0, interrupt=0, led_out=0.
  - FIFO empty, so ext_ready=1.
  - overflow=0, irq_en=0, IRQ FSM in IDLE.
- Register map, full 8-bit compare against BASE_ADDR+n. A write is (write_strobe | k_write_strobe) on the same cycle as port_id/out_port; both strobes are treated identically.
  - +0: W sets led_out <= out_port. R returns led_out.
  - +1: R returns STATUS {5'b0, overflow, full, !empty}. W with out_port[2]=1 clears overflow; other bits ignored.
  - +2: R returns the FIFO head, or 8'h00 when empty. read_strobe at this address pops one entry if non-empty; no effect if empty. Writes ignored.
  - +3: W sets irq_en <= out_port[0]. R returns {7'b0, irq_en}.
  - +4: timer (see Optional Feature). Unmapped addresses read 8'h00.
- in_port is registered from the port_id decode every clock, so latency is 1 cycle after port_id changes. The processor holds port_id for 2 cycles, so data is valid when read_strobe is high. in_port is not qualified by read_strobe.
- The pop takes effect at the edge ending the read_strobe cycle. The new head appears on in_port the following cycle.
- FIFO:
  - Push when ext_valid && ext_ready.
  - ext_valid && full sets overflow (sticky) and the byte is dropped.
  - Push and pop in the same cycle: the count is unchanged and both happen.
  - Pointers wrap modulo FIFO_DEPTH.
  - full when count==FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
  - If the overflow clear and an overflow event coincide, overflow stays 1.
- IRQ FSM:
  - IDLE: interrupt=0. Go to PEND when irq_en && !empty.
  - PEND: interrupt=1. On interrupt_ack go to SERVICED. If irq_en clears, go to IDLE.
  - SERVICED: interrupt=0. Go to IDLE once the FIFO is empty (prevents an interrupt storm while the ISR drains).
  - interrupt_ack in IDLE or SERVICED is ignored.
- Reset asserted mid-transfer discards all FIFO contents and pending interrupt state immediately.

Optional Feature:
- Macro: PICO_IO_TIMER_EN.
- Defined: adds an 8-bit free-running counter at BASE_ADDR+4.
  - Increments once every TIMER_DIV clocks and wraps 8'hFF->8'h00.
  - A write of any value clears both the counter and the prescaler.
  - Reset value is 0.
- Undefined: no counter or prescaler logic. +4 reads 8'h00 and writes are ignored.

Test Plan:
- Reset then write: after reset, check led_out=0, in_port=0, ext_ready=1. Then write_strobe, port_id=BASE+0, out_port=8'hF3 -> led_out=8'hF3 next cycle; reading +0 gives in_port=8'hF3.
- OUTPUTK write: k_write_strobe, port_id=BASE+0, out_port=8'h60 -> led_out=8'h60. Write to BASE+7 -> no register changes.
- FIFO order: push 8'hA1, 8'hB2, 8'hC3. STATUS reads 8'h01. Three reads of +2 return A1, B2, C3 in order. STATUS then reads 8'h00; a further read of +2 returns 8'h00.
- Fill and overflow: push FIFO_DEPTH bytes -> ext_ready=0, STATUS=8'h03. Assert ext_valid once more -> STATUS=8'h07 and the byte is dropped. Write +1 with out_port=8'h04 -> STATUS=8'h03.
- Simultaneous push and pop with 1 entry: count stays 1, new byte becomes head.
- Interrupt handshake: write +3 with 8'h01, push 1 byte -> interrupt=1 next cycle. Pulse interrupt_ack -> interrupt=0. Push another byte before draining -> interrupt stays 0. Pop both, push again -> interrupt=1.
- Timer (macro defined, TIMER_DIV=4): after 40 clocks, +4 reads 8'h0A. Write +4 -> reads 8'h00. With the macro undefined, +4 always reads 8'h00.
